// File: rtl/chi_mask_prng_if.sv
// Seed / fresh-mask handshake bundle between the round controller and the mask PRNG.
interface chi_mask_prng_if #(
    parameter int unsigned RAND_WIDTH = 64
);
    logic [31:0]           seed_in;
    logic                  seed_valid;
    logic                  seed_ready;
    logic                  reseed;
    logic [RAND_WIDTH-1:0] r;
    logic                  r_valid;
    logic                  r_ready;

    // Controller side: supplies seeds and consumes mask words.
    modport master (
        output seed_in, seed_valid, reseed, r_ready,
        input  seed_ready, r, r_valid
    );

    // PRNG side.
    modport slave (
        input  seed_in, seed_valid, reseed, r_ready,
        output seed_ready, r, r_valid
    );
endinterface

// File: rtl/chi_mask_prng.sv
// Fresh-mask generator for the masked chi layer: NUM_LANES parallel 32-bit
// Galois LFSRs, seeded word-serially, optionally warmed up, then stepped once
// per consumed mask word.
module chi_mask_prng #(
    parameter int unsigned RAND_WIDTH    = 64,
    parameter int          WARMUP_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    chi_mask_prng_if.slave  bus
);
    localparam int unsigned NUM_LANES = RAND_WIDTH / 32;
    localparam int unsigned CNT_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned WCNT_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [31:0] POLY      = 32'h80200003;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_LANES - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              cnt, cnt_nxt;
    logic [WCNT_W-1:0]             wcnt, wcnt_nxt;
    logic [NUM_LANES-1:0][31:0]    lane, lane_nxt;
    logic                          seed_ready;
    logic                          r_valid;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    assign bus.seed_ready = seed_ready;
    assign bus.r_valid    = r_valid;
    assign bus.r          = lane;

    // State, counters, lanes and the decoded handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEED;
            cnt        <= '0;
            wcnt       <= '0;
            lane       <= '0;
            seed_ready <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wcnt       <= wcnt_nxt;
            lane       <= lane_nxt;
            seed_ready <= (state_nxt == SEED);
            r_valid    <= (state_nxt == RUN);
        end
    end

    // Next-state, seed loading, warmup counting and lane stepping.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wcnt_nxt  = wcnt;
        lane_nxt  = lane;
        unique case (state)
            SEED: begin
                if (bus.seed_valid && seed_ready) begin
                    // An all-zero lane would never leave zero.
                    lane_nxt[cnt] = (bus.seed_in == 32'h0) ? 32'h1 : bus.seed_in;
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            WARMUP: begin
                for (int k = 0; k < int'(NUM_LANES); k++) begin
                    lane_nxt[k] = lfsr_step(lane[k]);
                end
                if (bus.reseed) begin
                    state_nxt = SEED;
                    cnt_nxt   = '0;
                    wcnt_nxt  = '0;
                end else if (wcnt == WCNT_LAST) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end
            RUN: begin
                if (r_valid && bus.r_ready) begin
                    for (int k = 0; k < int'(NUM_LANES); k++) begin
                        lane_nxt[k] = lfsr_step(lane[k]);
                    end
                end
                if (bus.reseed) begin
                    state_nxt = SEED;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = SEED;
                cnt_nxt   = '0;
                wcnt_nxt  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_chi_mask_prng.sv
// Bench for chi_mask_prng: one instance without warmup, one with 16 warmup steps.
module tb_chi_mask_prng;
    localparam logic [31:0] POLY = 32'h80200003;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;
    logic [31:0] m [2];

    always #5 clk = ~clk;

    chi_mask_prng_if #(.RAND_WIDTH(64)) b0 ();
    chi_mask_prng_if #(.RAND_WIDTH(64)) b16 ();

    chi_mask_prng #(.RAND_WIDTH(64), .WARMUP_CYCLES(0))  dut0  (.clk(clk), .rst(rst), .bus(b0.slave));
    chi_mask_prng #(.RAND_WIDTH(64), .WARMUP_CYCLES(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

    // Reference: one Galois step, taps 0x80200003, right shift.
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] t;
        t = s / 2;
        if (s % 2 == 1) t = t ^ POLY;
        return t;
    endfunction

    function automatic logic [63:0] model_word();
        return {m[1], m[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_advance();
        m[0] = ref_step(m[0]);
        m[1] = ref_step(m[1]);
    endtask

    // Load two seed words into dut0; model applies the zero-seed substitution.
    task automatic seed0(input logic [31:0] a, input logic [31:0] b);
        b0.seed_valid = 1'b1;
        b0.seed_in    = a;
        tick();
        b0.seed_in    = b;
        tick();
        b0.seed_valid = 1'b0;
        b0.seed_in    = 32'h0;
        m[0] = (a == 32'h0) ? 32'h1 : a;
        m[1] = (b == 32'h0) ? 32'h1 : b;
    endtask

    task automatic test_reset();
        b0.seed_in = 0; b0.seed_valid = 0; b0.reseed = 0; b0.r_ready = 0;
        b16.seed_in = 0; b16.seed_valid = 0; b16.reseed = 0; b16.r_ready = 0;
        rst = 1'b1;
        tick();
        tick();
        vecs++;
        if ({b0.seed_ready, b0.r_valid, b0.r} !== 66'h0) begin
            errs++;
            $display("FAIL reset_outputs: got ready=%b valid=%b r=%h, want all 0",
                     b0.seed_ready, b0.r_valid, b0.r);
        end
        vecs++;
        if ({b16.seed_ready, b16.r_valid, b16.r} !== 66'h0) begin
            errs++;
            $display("FAIL reset_outputs_w16: got ready=%b valid=%b r=%h, want all 0",
                     b16.seed_ready, b16.r_valid, b16.r);
        end
        rst = 1'b0;
        tick();
        vecs++;
        if (b0.seed_ready !== 1'b1 || b0.r_valid !== 1'b0) begin
            errs++;
            $display("FAIL post_reset: got ready=%b valid=%b, want 1 0", b0.seed_ready, b0.r_valid);
        end
    endtask

    task automatic test_seed();
        seed0(32'h1, 32'h1);
        vecs++;
        if (b0.r_valid !== 1'b1 || b0.r !== 64'h00000001_00000001) begin
            errs++;
            $display("FAIL seed_11: got valid=%b r=%h, want 1 0000000100000001", b0.r_valid, b0.r);
        end
    endtask

    task automatic test_stepping();
        logic [63:0] exp [2];
        exp[0] = 64'h80200003_80200003;
        exp[1] = 64'hC0300002_C0300002;
        b0.r_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            model_advance();
            vecs++;
            if (b0.r !== exp[i]) begin
                errs++;
                $display("FAIL step_%0d: got %h want %h", i, b0.r, exp[i]);
            end
        end
        // Random consumer pattern, including back-to-back runs.
        for (int i = 0; i < 40; i++) begin
            b0.r_ready = 1'($urandom_range(0, 1));
            if (b0.r_ready && b0.r_valid) model_advance();
            tick();
            vecs++;
            if (b0.r_valid !== 1'b1 || b0.r !== model_word()) begin
                errs++;
                $display("FAIL random_step_%0d: got valid=%b r=%h want 1 %h", i, b0.r_valid, b0.r, model_word());
            end
        end
        b0.r_ready = 1'b0;
    endtask

    task automatic do_reseed();
        b0.reseed = 1'b1;
        tick();
        b0.reseed = 1'b0;
        vecs++;
        if (b0.r_valid !== 1'b0 || b0.seed_ready !== 1'b1) begin
            errs++;
            $display("FAIL reseed_state: got valid=%b ready=%b want 0 1", b0.r_valid, b0.seed_ready);
        end
    endtask

    task automatic test_zero_seed();
        logic [31:0] a, b;
        do_reseed();
        seed0(32'h0, 32'h5);
        vecs++;
        if (b0.r !== 64'h00000005_00000001) begin
            errs++;
            $display("FAIL zero_seed: got %h want 0000000500000001", b0.r);
        end
        // Random reseed rounds, each followed by a few consumed words.
        for (int j = 0; j < 4; j++) begin
            do_reseed();
            a = $urandom();
            b = (j == 0) ? 32'h0 : $urandom();
            seed0(a, b);
            vecs++;
            if (b0.r !== model_word()) begin
                errs++;
                $display("FAIL rand_seed_%0d: got %h want %h", j, b0.r, model_word());
            end
            b0.r_ready = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                model_advance();
                vecs++;
                if (b0.r !== model_word()) begin
                    errs++;
                    $display("FAIL rand_seed_run_%0d_%0d: got %h want %h", j, i, b0.r, model_word());
                end
            end
            b0.r_ready = 1'b0;
        end
    endtask

    task automatic test_warmup();
        int          n;
        logic [31:0] e;
        b16.seed_valid = 1'b1;
        b16.seed_in    = 32'h1;
        tick();
        tick();
        b16.seed_valid = 1'b0;
        b16.seed_in    = 32'h0;
        n = 0;
        while (b16.r_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vecs++;
        if (n != 16) begin
            errs++;
            $display("FAIL warmup_latency: got %0d cycles want 16", n);
        end
        e = 32'h1;
        for (int i = 0; i < 16; i++) e = ref_step(e);
        vecs++;
        if (b16.r !== {e, e}) begin
            errs++;
            $display("FAIL warmup_word: got %h want %h", b16.r, {e, e});
        end
    endtask

    task automatic test_backpressure_reseed();
        b0.r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // Stray seed words in RUN must not disturb the lanes.
            b0.seed_valid = (i == 2);
            b0.seed_in    = $urandom();
            tick();
            vecs++;
            if (b0.r_valid !== 1'b1 || b0.r !== model_word()) begin
                errs++;
                $display("FAIL stall_%0d: got valid=%b r=%h want 1 %h", i, b0.r_valid, b0.r, model_word());
            end
        end
        b0.seed_valid = 1'b0;
        b0.reseed  = 1'b1;
        b0.r_ready = 1'b1;
        tick();
        b0.reseed  = 1'b0;
        b0.r_ready = 1'b0;
        model_advance();
        vecs++;
        if (b0.r_valid !== 1'b0 || b0.seed_ready !== 1'b1 || b0.r !== model_word()) begin
            errs++;
            $display("FAIL reseed_with_ready: got valid=%b ready=%b r=%h want 0 1 %h",
                     b0.r_valid, b0.seed_ready, b0.r, model_word());
        end
    endtask

    task automatic test_reset_mid_seed();
        b0.seed_valid = 1'b1;
        b0.seed_in    = 32'h3;
        tick();
        b0.seed_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        vecs++;
        if (b0.seed_ready !== 1'b1 || b0.r !== 64'h0) begin
            errs++;
            $display("FAIL mid_seed_reset: got ready=%b r=%h want 1 0", b0.seed_ready, b0.r);
        end
        seed0(32'h7, 32'h9);
        vecs++;
        if (b0.r_valid !== 1'b1 || b0.r !== 64'h00000009_00000007) begin
            errs++;
            $display("FAIL mid_seed_reseq: got valid=%b r=%h want 1 0000000900000007", b0.r_valid, b0.r);
        end
    endtask

    initial begin
        test_reset();
        test_seed();
        test_stepping();
        test_zero_seed();
        test_warmup();
        test_backpressure_reseed();
        test_reset_mid_seed();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
